// File: rtl/llki_mock_pkg.sv
// Shared types and constants for the mock LLKI key-gated write path.
// Used by llki_mock_keygate (optional write lock: LLKI_KEY_LOCK_EN).
package llki_mock_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE   = 2'd0,
        KEY_LOAD   = 2'd1,
        KEY_LOADED = 2'd2
    } key_state_e;

    localparam logic [127:0] DEFAULT_EXPECTED_KEY = 128'h0123456789ABCDEF_FEDCBA9876543210;

    // Number of DATA_W-wide mask slices that tile the key.
    function automatic int calc_num_slices(input int key_w, input int data_w);
        return key_w / data_w;
    endfunction

    // Index width for n entries, never narrower than one bit.
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/llki_mock_key_loader.sv
// Key loading FSM: collects KEY_WORDS 64-bit words MSB-slot first, commits
// the key, flags a match against EXPECTED_KEY and produces the data mask.
module llki_mock_key_loader
    import llki_mock_pkg::*;
#(
    parameter int                        KEY_WORDS    = 2,
    parameter logic [64*KEY_WORDS-1:0]   EXPECTED_KEY = DEFAULT_EXPECTED_KEY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [63:0]             key_word,
    output logic                    key_ready,
    input  logic                    key_clear,
    output logic                    key_loaded,
    output logic                    key_match,
    output logic [64*KEY_WORDS-1:0] mask
);

    localparam int KEY_W = 64 * KEY_WORDS;
    localparam int CNT_W = calc_idx_w(KEY_WORDS);

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] key_reg_q, key_reg_d;
    logic             match_q, match_d;
    logic             accept;

    assign key_loaded = (state_q == KEY_LOADED);
    assign key_ready  = ~key_loaded;
    assign key_match  = match_q;
    assign accept     = key_valid & key_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_reg_d = key_reg_q;
        match_d   = match_q;
        if (key_clear) begin
            state_d   = KEY_IDLE;
            cnt_d     = '0;
            key_reg_d = '0;
            match_d   = 1'b0;
        end else if (accept) begin
            // Word n lands in slot KEY_WORDS-1-n, so the first word is the MSBs.
            for (int w = 0; w < KEY_WORDS; w++) begin
                if (w == KEY_WORDS - 1 - int'(cnt_q)) begin
                    key_reg_d[w*64 +: 64] = key_word;
                end
            end
            if (int'(cnt_q) == KEY_WORDS - 1) begin
                state_d = KEY_LOADED;
                cnt_d   = '0;
                match_d = (key_reg_d == EXPECTED_KEY);
            end else begin
                state_d = KEY_LOAD;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= KEY_IDLE;
            cnt_q     <= '0;
            key_reg_q <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_reg_q <= key_reg_d;
            match_q   <= match_d;
        end
    end

    // A correct key cancels the mask to zero; anything else scrambles data.
    assign mask = key_loaded ? (EXPECTED_KEY ^ key_reg_q) : EXPECTED_KEY;

endmodule

// File: rtl/llki_mock_keygate.sv
// Mock LLKI key gate: per-channel write data is XORed with a rotating key-mask
// slice. Define LLKI_KEY_LOCK_EN to suppress writes entirely until the key matches.
module llki_mock_keygate
    import llki_mock_pkg::*;
#(
    parameter int                        NUM_CH       = 3,
    parameter int                        DATA_W       = 32,
    parameter int                        KEY_WORDS    = 2,
    parameter logic [64*KEY_WORDS-1:0]   EXPECTED_KEY = DEFAULT_EXPECTED_KEY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [63:0]              key_word,
    output logic                     key_ready,
    input  logic                     key_clear,
    output logic                     key_loaded,
    output logic                     key_match,
    input  logic [NUM_CH-1:0]        ch_cs,
    input  logic [NUM_CH-1:0]        ch_wr,
    input  logic [NUM_CH-1:0]        ch_rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_cs_out,
    output logic [NUM_CH-1:0]        ch_wr_out,
    output logic [NUM_CH-1:0]        ch_rst_out,
    output logic [NUM_CH*DATA_W-1:0] ch_wdata_out
);

    localparam int KEY_W = 64 * KEY_WORDS;
    localparam int NS    = calc_num_slices(KEY_W, DATA_W);
    localparam int PTR_W = calc_idx_w(NS);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NS - 1);
    // Pointer value after a write that coincides with a pointer reset.
    localparam logic [PTR_W-1:0] AFTER_RST = (NS > 1) ? PTR_W'(1) : '0;

    logic [KEY_W-1:0]  mask;
    logic [DATA_W-1:0] mask_slice [NS];

    llki_mock_key_loader #(
        .KEY_WORDS    (KEY_WORDS),
        .EXPECTED_KEY (EXPECTED_KEY)
    ) u_key_loader (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_word   (key_word),
        .key_ready  (key_ready),
        .key_clear  (key_clear),
        .key_loaded (key_loaded),
        .key_match  (key_match),
        .mask       (mask)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_slice
            assign mask_slice[gi] = mask[gi*DATA_W +: DATA_W];
        end

        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic              wr_en;
            logic [PTR_W-1:0]  sel;
            logic [PTR_W-1:0]  ptr_q, ptr_d;
            logic              cs_q, cs_d;
            logic              wr_q, wr_d;
            logic              rst_out_q, rst_out_d;
            logic [DATA_W-1:0] wdata_q, wdata_d;

            always_comb begin
                wr_en     = ch_cs[gi] & ch_wr[gi];
                sel       = ch_rst[gi] ? '0 : ptr_q;
                ptr_d     = ptr_q;
                if (ch_rst[gi]) begin
                    ptr_d = wr_en ? AFTER_RST : '0;
                end else if (wr_en) begin
                    ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
                end
                cs_d      = ch_cs[gi];
                wr_d      = ch_wr[gi];
                rst_out_d = ch_rst[gi];
                wdata_d   = ch_wdata[gi*DATA_W +: DATA_W] ^ mask_slice[sel];
`ifdef LLKI_KEY_LOCK_EN
                // Pointers keep tracking so a later unlock stays in step with the host.
                if (!key_match) begin
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    wdata_d = '0;
                end
`endif
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ptr_q     <= '0;
                    cs_q      <= 1'b0;
                    wr_q      <= 1'b0;
                    rst_out_q <= 1'b0;
                    wdata_q   <= '0;
                end else begin
                    ptr_q     <= ptr_d;
                    cs_q      <= cs_d;
                    wr_q      <= wr_d;
                    rst_out_q <= rst_out_d;
                    wdata_q   <= wdata_d;
                end
            end

            assign ch_cs_out[gi]                     = cs_q;
            assign ch_wr_out[gi]                     = wr_q;
            assign ch_rst_out[gi]                    = rst_out_q;
            assign ch_wdata_out[gi*DATA_W +: DATA_W] = wdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_llki_mock_keygate.sv
// Scoreboard bench for llki_mock_keygate: directed scenarios plus random traffic
// checked against a word-list / pointer-array reference model.
module tb_llki_mock_keygate;

    localparam int NC = 3;
    localparam int DW = 32;
    localparam int KW = 2;
    localparam int NS = (64 * KW) / DW;
    localparam logic [127:0] EXP = 128'h0123456789ABCDEF_FEDCBA9876543210;

    typedef struct packed {
        logic          kr;
        logic          kl;
        logic          km;
        logic [NC-1:0] cs;
        logic [NC-1:0] wr;
        logic [NC-1:0] rs;
        logic [NC*DW-1:0] wd;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_valid = 1'b0;
    logic [63:0]      key_word = '0;
    logic             key_ready;
    logic             key_clear = 1'b0;
    logic             key_loaded;
    logic             key_match;
    logic [NC-1:0]    ch_cs = '0;
    logic [NC-1:0]    ch_wr = '0;
    logic [NC-1:0]    ch_rst = '0;
    logic [NC*DW-1:0] ch_wdata = '0;
    logic [NC-1:0]    ch_cs_out;
    logic [NC-1:0]    ch_wr_out;
    logic [NC-1:0]    ch_rst_out;
    logic [NC*DW-1:0] ch_wdata_out;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_txn   = 0;
    rec_t exp_q[$];

    // Reference model state: accepted key words in arrival order, per-channel pointers.
    logic [63:0] m_words[$];
    int          m_ptr[NC];

    always #5 clk = ~clk;

    llki_mock_keygate dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_word     (key_word),
        .key_ready    (key_ready),
        .key_clear    (key_clear),
        .key_loaded   (key_loaded),
        .key_match    (key_match),
        .ch_cs        (ch_cs),
        .ch_wr        (ch_wr),
        .ch_rst       (ch_rst),
        .ch_wdata     (ch_wdata),
        .ch_cs_out    (ch_cs_out),
        .ch_wr_out    (ch_wr_out),
        .ch_rst_out   (ch_rst_out),
        .ch_wdata_out (ch_wdata_out)
    );

    function automatic logic m_loaded();
        return m_words.size() == KW;
    endfunction

    function automatic logic [127:0] m_key();
        logic [127:0] k = '0;
        for (int i = 0; i < m_words.size(); i++) k[127 - 64*i -: 64] = m_words[i];
        return k;
    endfunction

    function automatic logic m_match();
        return m_loaded() && (m_key() == EXP);
    endfunction

    function automatic logic [127:0] m_mask();
        return m_loaded() ? (EXP ^ m_key()) : EXP;
    endfunction

    // Expected output word for a directed write, accounting for the optional lock.
    function automatic logic [31:0] lv(input logic [31:0] v);
`ifdef LLKI_KEY_LOCK_EN
        if (!m_match()) return 32'h0;
`endif
        return v;
    endfunction

    function automatic void chk(input string name, input logic [NC*DW-1:0] act, input logic [NC*DW-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s txn=%0d actual=%h required=%h", name, n_txn, act, expv);
        end
    endfunction

    task automatic step(input logic r, input logic kv, input logic [63:0] kw, input logic kc,
                        input logic [NC-1:0] cs, input logic [NC-1:0] wr, input logic [NC-1:0] crs,
                        input logic [NC*DW-1:0] wd,
                        input int oc0, input logic [31:0] ov0, input int oc1, input logic [31:0] ov1);
        rec_t         e;
        logic [127:0] msk;
        logic         mt;
        int           idx;
        logic         w;
        @(negedge clk);
        rst = r; key_valid = kv; key_word = kw; key_clear = kc;
        ch_cs = cs; ch_wr = wr; ch_rst = crs; ch_wdata = wd;
        e = '0;
        if (r) begin
            m_words.delete();
            for (int c = 0; c < NC; c++) m_ptr[c] = 0;
            e.kr = 1'b1;
        end else begin
            msk = m_mask();
            mt  = m_match();
            for (int c = 0; c < NC; c++) begin
                w   = cs[c] & wr[c];
                idx = crs[c] ? 0 : m_ptr[c];
                e.cs[c] = cs[c];
                e.wr[c] = wr[c];
                e.rs[c] = crs[c];
                e.wd[c*DW +: DW] = wd[c*DW +: DW] ^ msk[idx*DW +: DW];
`ifdef LLKI_KEY_LOCK_EN
                if (!mt) begin
                    e.cs[c] = 1'b0;
                    e.wr[c] = 1'b0;
                    e.wd[c*DW +: DW] = '0;
                end
`endif
                if (crs[c]) m_ptr[c] = w ? (1 % NS) : 0;
                else if (w) m_ptr[c] = (m_ptr[c] + 1) % NS;
            end
            if (kc) m_words.delete();
            else if (kv && m_words.size() < KW) m_words.push_back(kw);
            e.kl = m_loaded();
            e.kr = ~e.kl;
            e.km = m_match();
            if (mt) e.km = e.km; // match held: recomputed from unchanged words
        end
        if (oc0 >= 0) e.wd[oc0*DW +: DW] = ov0;
        if (oc1 >= 0) e.wd[oc1*DW +: DW] = ov1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0, '0, '0, -1, 0, -1, 0);
    endtask

    task automatic load(input logic [63:0] kw);
        step(0, 1, kw, 0, '0, '0, '0, '0, -1, 0, -1, 0);
    endtask

    // Monitor: every registered cycle the DUT presents is compared against the queue head.
    initial begin
        rec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("key_ready",    NC*DW'(key_ready),  NC*DW'(e.kr));
                chk("key_loaded",   NC*DW'(key_loaded), NC*DW'(e.kl));
                chk("key_match",    NC*DW'(key_match),  NC*DW'(e.km));
                chk("ch_cs_out",    NC*DW'(ch_cs_out),  NC*DW'(e.cs));
                chk("ch_wr_out",    NC*DW'(ch_wr_out),  NC*DW'(e.wr));
                chk("ch_rst_out",   NC*DW'(ch_rst_out), NC*DW'(e.rs));
                chk("ch_wdata_out", ch_wdata_out,       e.wd);
                $display("[TB] txn %0d kr=%b kl=%b km=%b cs=%b wr=%b rs=%b wdata=%h",
                         n_txn, key_ready, key_loaded, key_match, ch_cs_out, ch_wr_out,
                         ch_rst_out, ch_wdata_out);
                n_txn++;
            end
        end
    end

    initial begin
        logic [127:0] exp_key;
        logic [63:0]  kw;
        int           guard;
        exp_key = EXP;

        step(1, 0, '0, 0, '0, '0, '0, '0, -1, 0, -1, 0);
        step(1, 0, '0, 0, '0, '0, '0, '0, -1, 0, -1, 0);
        idle(1);

        // No key: ch0 walks through all four slices and wraps.
        step(0, 0, '0, 0, 3'b001, 3'b001, 3'b000, '0, 0, lv(32'h76543210), -1, 0);
        step(0, 0, '0, 0, 3'b001, 3'b001, 3'b000, '0, 0, lv(32'hFEDCBA98), -1, 0);
        step(0, 0, '0, 0, 3'b001, 3'b001, 3'b000, '0, 0, lv(32'h89ABCDEF), -1, 0);
        step(0, 0, '0, 0, 3'b001, 3'b001, 3'b000, '0, 0, lv(32'h01234567), -1, 0);
        step(0, 0, '0, 0, 3'b001, 3'b001, 3'b000, '0, 0, lv(32'h76543210), -1, 0);

        // ch2 advanced to ptr 3, then ch1 reset+write alongside ch2 write.
        step(0, 0, '0, 0, 3'b100, 3'b100, 3'b000, '0, -1, 0, -1, 0);
        step(0, 0, '0, 0, 3'b100, 3'b100, 3'b000, '0, -1, 0, -1, 0);
        step(0, 0, '0, 0, 3'b100, 3'b100, 3'b000, '0, -1, 0, -1, 0);
        step(0, 0, '0, 0, 3'b110, 3'b110, 3'b010, '0, 1, lv(32'h76543210), 2, lv(32'h01234567));
        step(0, 0, '0, 0, 3'b110, 3'b110, 3'b000, '0, 1, lv(32'hFEDCBA98), 2, lv(32'h76543210));

        // Correct key: mask cancels.
        load(64'h0123456789ABCDEF);
        load(64'hFEDCBA9876543210);
        idle(1);
        step(0, 0, '0, 0, 3'b001, 3'b001, 3'b000, {64'h0, 32'hDEADBEEF}, 0, 32'hDEADBEEF, -1, 0);

        // Clear racing a key word, then a fresh load.
        step(0, 0, '0, 1, '0, '0, '0, '0, -1, 0, -1, 0);
        load(64'h0123456789ABCDEF);
        step(0, 1, 64'hFEDCBA9876543210, 1, '0, '0, '0, '0, -1, 0, -1, 0);
        idle(1);
        load(64'h0123456789ABCDEF);
        load(64'hFEDCBA9876543210);
        idle(1);
        step(0, 0, '0, 0, 3'b010, 3'b010, 3'b000, {32'h0, 32'hDEADBEEF, 32'h0}, 1, 32'hDEADBEEF, -1, 0);

        // Wrong second word: slice 0 scrambled by a single bit.
        step(0, 0, '0, 1, '0, '0, '0, '0, -1, 0, -1, 0);
        load(64'h0123456789ABCDEF);
        load(64'hFEDCBA9876543211);
        idle(1);
        step(0, 0, '0, 0, 3'b001, 3'b001, 3'b001, '0, 0, lv(32'h00000001), -1, 0);

        // Reset mid-load discards the partial key and zeroes every pointer.
        step(0, 0, '0, 1, '0, '0, '0, '0, -1, 0, -1, 0);
        load(64'h0123456789ABCDEF);
        step(1, 0, '0, 0, '0, '0, '0, '0, -1, 0, -1, 0);
        step(0, 0, '0, 0, 3'b111, 3'b111, 3'b000, '0, 0, lv(32'h76543210), 2, lv(32'h76543210));
        load(64'h0123456789ABCDEF);
        load(64'hFEDCBA9876543210);
        idle(1);

        // Random traffic, biased towards correct key words so matches occur.
        for (int i = 0; i < 1500; i++) begin
            if (m_words.size() < KW && $urandom_range(3) != 0)
                kw = exp_key[127 - 64*m_words.size() -: 64];
            else
                kw = {$urandom, $urandom};
            step(($urandom_range(99) == 0), 1'($urandom), kw, ($urandom_range(39) == 0),
                 3'($urandom), 3'($urandom), 3'($urandom & $urandom & $urandom),
                 {$urandom, $urandom, $urandom}, -1, 0, -1, 0);
        end
        idle(2);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
